// File: rtl/xcvr_loopback_pkg.sv
// Shared constants for the transceiver loopback pattern path: 8b/10b alignment
// characters, PRBS7 polynomial taps and the generator state encoding.
package xcvr_loopback_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] D16_2 = 8'h50;

    // x^7 + x^6 + 1: feedback from state bits 6 and 5
    localparam int PRBS7_LEN   = 7;
    localparam int PRBS7_TAP_A = 6;
    localparam int PRBS7_TAP_B = 5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ALIGN = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

endpackage

// File: rtl/prbs_pattern_gen_if.sv
// Control and TX word bundle between the pattern generator and its neighbours.
// master = generator side; slave = startup stage / TX lane side.
interface prbs_pattern_gen_if #(
    parameter int DATA_WIDTH = 32
);
    logic                      start_gen_i;
    logic                      inject_err_i;
    logic [DATA_WIDTH-1:0]     tx_data_o;
    logic [DATA_WIDTH/8-1:0]   tx_k_o;
    logic                      pattern_valid_o;
    logic                      align_done_o;
    logic [31:0]               word_count_o;

    modport master (
        input  start_gen_i,
        input  inject_err_i,
        output tx_data_o,
        output tx_k_o,
        output pattern_valid_o,
        output align_done_o,
        output word_count_o
    );

    modport slave (
        output start_gen_i,
        output inject_err_i,
        input  tx_data_o,
        input  tx_k_o,
        input  pattern_valid_o,
        input  align_done_o,
        input  word_count_o
    );
endinterface

// File: rtl/prbs7_par.sv
// Parallel PRBS7: DATA_WIDTH serial steps unrolled, first bit lands in the MSB.
// Purely combinational, no backpressure; shared with the pattern checker.
module prbs7_par
    import xcvr_loopback_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [PRBS7_LEN-1:0]  lfsr_in,
    output logic [DATA_WIDTH-1:0] word,
    output logic [PRBS7_LEN-1:0]  lfsr_next
);

    logic [PRBS7_LEN-1:0] s;
    logic                 fb;

    always_comb begin
        s    = lfsr_in;
        fb   = 1'b0;
        word = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            fb                   = s[PRBS7_TAP_A] ^ s[PRBS7_TAP_B];
            word[DATA_WIDTH-1-i] = fb;
            s                    = {s[PRBS7_LEN-2:0], fb};
        end
        lfsr_next = s;
    end

endmodule

// File: rtl/prbs_pattern_gen.sv
// Loopback TX generator: K28.5/D16.2 preamble then continuous PRBS7, registered outputs.
// One cycle from start_gen_i to first word; no backpressure, the TX lane takes a word every cycle.
module prbs_pattern_gen
    import xcvr_loopback_pkg::*;
#(
    parameter int             DATA_WIDTH  = 32,
    parameter int             ALIGN_WORDS = 16,
    parameter logic [6:0]     PRBS_SEED   = 7'h7F
) (
    input  logic              tx_clk_i,
    input  logic              pattern_gen_n_i,
    prbs_pattern_gen_if.master pg
);

    localparam int         KW         = DATA_WIDTH / 8;
    localparam logic [7:0] ALIGN_LAST = 8'(ALIGN_WORDS);

    logic [1:0]            state;
    logic [PRBS7_LEN-1:0]  lfsr;
    logic [PRBS7_LEN-1:0]  lfsr_next;
    logic [7:0]            align_cnt;
    logic [DATA_WIDTH-1:0] prbs_word;
    logic [DATA_WIDTH-1:0] align_dat;
    logic [KW-1:0]         align_k;

    logic [DATA_WIDTH-1:0] tx_data_q;
    logic [KW-1:0]         tx_k_q;
    logic                  valid_q;
    logic                  done_q;
    logic [31:0]           word_cnt_q;

    prbs7_par #(.DATA_WIDTH(DATA_WIDTH)) u_prbs (
        .lfsr_in   (lfsr),
        .word      (prbs_word),
        .lfsr_next (lfsr_next)
    );

    // Even bytes carry the comma so the receiver can byte-align on any lane width
    always_comb begin
        align_dat = '0;
        align_k   = '0;
        for (int b = 0; b < KW; b++) begin
            if ((b % 2) == 0) begin
                align_dat[8*b +: 8] = K28_5;
                align_k[b]          = 1'b1;
            end else begin
                align_dat[8*b +: 8] = D16_2;
                align_k[b]          = 1'b0;
            end
        end
    end

    always_ff @(posedge tx_clk_i or negedge pattern_gen_n_i) begin
        if (!pattern_gen_n_i) begin
            state      <= ST_IDLE;
            lfsr       <= PRBS_SEED;
            align_cnt  <= '0;
            tx_data_q  <= '0;
            tx_k_q     <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            word_cnt_q <= '0;
        end else if (!pg.start_gen_i) begin
            state      <= ST_IDLE;
            lfsr       <= PRBS_SEED;
            align_cnt  <= '0;
            tx_data_q  <= '0;
            tx_k_q     <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state     <= ST_ALIGN;
                    tx_data_q <= align_dat;
                    tx_k_q    <= align_k;
                    align_cnt <= 8'd1;
                end
                ST_ALIGN: begin
                    // align_cnt counts words already on the wire
                    if (align_cnt == ALIGN_LAST) begin
                        state      <= ST_RUN;
                        tx_data_q  <= prbs_word;
                        tx_k_q     <= '0;
                        valid_q    <= 1'b1;
                        done_q     <= 1'b1;
                        word_cnt_q <= 32'd1;
                        lfsr       <= lfsr_next;
                    end else begin
                        tx_data_q <= align_dat;
                        tx_k_q    <= align_k;
                        align_cnt <= align_cnt + 8'd1;
                    end
                end
                ST_RUN: begin
                    // Corruption is applied after the LFSR so the stream stays in step
                    tx_data_q <= prbs_word ^ {{(DATA_WIDTH-1){1'b0}}, pg.inject_err_i};
                    lfsr      <= lfsr_next;
                    if (word_cnt_q != 32'hFFFF_FFFF) begin
                        word_cnt_q <= word_cnt_q + 32'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pg.tx_data_o       = tx_data_q;
    assign pg.tx_k_o          = tx_k_q;
    assign pg.pattern_valid_o = valid_q;
    assign pg.align_done_o    = done_q;
    assign pg.word_count_o    = word_cnt_q;

endmodule

// File: tb/tb_prbs_pattern_gen.sv
// Directed bench for prbs_pattern_gen: preamble, PRBS7 stream vs serial model,
// error injection, stop/restart and asynchronous reset.
module tb_prbs_pattern_gen;

    logic tx_clk = 1'b0;
    logic rst_n  = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [6:0]  m_s;
    logic [31:0] seen [0:253];

    always #5 tx_clk = ~tx_clk;

    prbs_pattern_gen_if #(.DATA_WIDTH(32)) pg_if ();

    prbs_pattern_gen #(
        .DATA_WIDTH  (32),
        .ALIGN_WORDS (16),
        .PRBS_SEED   (7'h7F)
    ) dut (
        .tx_clk_i        (tx_clk),
        .pattern_gen_n_i (rst_n),
        .pg              (pg_if)
    );

    // Serial reference: new = s6 ^ s5, first bit into the MSB
    task automatic model_step(output logic [31:0] w);
        logic nb;
        w = '0;
        for (int i = 0; i < 32; i++) begin
            nb        = m_s[6] ^ m_s[5];
            w[31 - i] = nb;
            m_s       = {m_s[5:0], nb};
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (pg_if.tx_data_o !== 32'h0 || pg_if.tx_k_o !== 4'h0 || pg_if.pattern_valid_o !== 1'b0 ||
            pg_if.align_done_o !== 1'b0 || pg_if.word_count_o !== 32'h0) begin
            errors++;
            $display("FAIL %s: data=%h k=%b valid=%b done=%b count=%0d, need all zero", name,
                     pg_if.tx_data_o, pg_if.tx_k_o, pg_if.pattern_valid_o, pg_if.align_done_o,
                     pg_if.word_count_o);
        end
    endtask

    task automatic test_reset();
        pg_if.start_gen_i  = 1'b1;
        pg_if.inject_err_i = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge tx_clk);
        #1;
        check_idle_outputs("reset_outputs");
        #2 rst_n = 1'b1;
        @(posedge tx_clk); #1;
        checks++;
        if (pg_if.tx_data_o !== 32'h50BC50BC || pg_if.tx_k_o !== 4'b0101) begin
            errors++;
            $display("FAIL first_align_word: data=%h k=%b, need 50bc50bc k=0101",
                     pg_if.tx_data_o, pg_if.tx_k_o);
        end
    endtask

    // Checks alignment words from_word..16, then the first PRBS word from seed
    task automatic test_preamble(input int from_word);
        logic [31:0] exp_w;
        for (int i = from_word; i <= 16; i++) begin
            @(posedge tx_clk); #1;
            checks++;
            if (pg_if.tx_data_o !== 32'h50BC50BC || pg_if.tx_k_o !== 4'b0101 ||
                pg_if.pattern_valid_o !== 1'b0 || pg_if.align_done_o !== 1'b0) begin
                errors++;
                $display("FAIL align_word_%0d: data=%h k=%b valid=%b done=%b, need 50bc50bc 0101 0 0",
                         i, pg_if.tx_data_o, pg_if.tx_k_o, pg_if.pattern_valid_o, pg_if.align_done_o);
            end
        end
        @(posedge tx_clk); #1;
        m_s = 7'h7F;
        model_step(exp_w);
        checks++;
        if (pg_if.tx_data_o[31:24] !== 8'h02) begin
            errors++;
            $display("FAIL first_prbs_byte: got %h need 02", pg_if.tx_data_o[31:24]);
        end
        checks++;
        if (pg_if.tx_data_o !== exp_w || pg_if.tx_k_o !== 4'h0 || pg_if.pattern_valid_o !== 1'b1 ||
            pg_if.align_done_o !== 1'b1 || pg_if.word_count_o !== 32'd1) begin
            errors++;
            $display("FAIL first_prbs_word: data=%h k=%b valid=%b done=%b count=%0d, need %h 0 1 1 1",
                     pg_if.tx_data_o, pg_if.tx_k_o, pg_if.pattern_valid_o, pg_if.align_done_o,
                     pg_if.word_count_o, exp_w);
        end
    endtask

    task automatic test_prbs_period();
        logic [31:0] exp_w;
        seen[0] = pg_if.tx_data_o;
        for (int i = 1; i < 254; i++) begin
            @(posedge tx_clk); #1;
            model_step(exp_w);
            seen[i] = pg_if.tx_data_o;
            checks++;
            if (pg_if.tx_data_o !== exp_w || pg_if.tx_k_o !== 4'h0 ||
                pg_if.word_count_o !== 32'(i + 1) || pg_if.pattern_valid_o !== 1'b1) begin
                errors++;
                $display("FAIL prbs_word_%0d: data=%h k=%b count=%0d valid=%b, need %h 0 %0d 1",
                         i + 1, pg_if.tx_data_o, pg_if.tx_k_o, pg_if.word_count_o,
                         pg_if.pattern_valid_o, exp_w, i + 1);
            end
        end
        for (int i = 0; i < 127; i++) begin
            checks++;
            if (seen[i + 127] !== seen[i]) begin
                errors++;
                $display("FAIL prbs_period_%0d: word %0d=%h, word %0d=%h, need equal",
                         i, i + 128, seen[i + 127], i + 1, seen[i]);
            end
        end
    endtask

    task automatic test_inject();
        logic [31:0] exp_w;
        pg_if.inject_err_i = 1'b1;
        @(posedge tx_clk); #1;
        pg_if.inject_err_i = 1'b0;
        model_step(exp_w);
        checks++;
        if (pg_if.tx_data_o !== (exp_w ^ 32'h1)) begin
            errors++;
            $display("FAIL inject_single: got %h need %h", pg_if.tx_data_o, exp_w ^ 32'h1);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge tx_clk); #1;
            model_step(exp_w);
            checks++;
            if (pg_if.tx_data_o !== exp_w) begin
                errors++;
                $display("FAIL inject_after_%0d: got %h need %h", i, pg_if.tx_data_o, exp_w);
            end
        end
        pg_if.inject_err_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge tx_clk); #1;
            model_step(exp_w);
            checks++;
            if (pg_if.tx_data_o !== (exp_w ^ 32'h1)) begin
                errors++;
                $display("FAIL inject_consec_%0d: got %h need %h", i, pg_if.tx_data_o, exp_w ^ 32'h1);
            end
        end
        pg_if.inject_err_i = 1'b0;
        @(posedge tx_clk); #1;
        model_step(exp_w);
        checks++;
        if (pg_if.tx_data_o !== exp_w) begin
            errors++;
            $display("FAIL inject_consec_clean: got %h need %h", pg_if.tx_data_o, exp_w);
        end
    endtask

    task automatic test_stop_restart();
        pg_if.start_gen_i = 1'b0;
        @(posedge tx_clk); #1;
        check_idle_outputs("stop_from_run");
        pg_if.start_gen_i = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            pg_if.inject_err_i = (i == 3);
            @(posedge tx_clk); #1;
            checks++;
            if (pg_if.tx_data_o !== 32'h50BC50BC || pg_if.tx_k_o !== 4'b0101) begin
                errors++;
                $display("FAIL restart_align_%0d: data=%h k=%b, need 50bc50bc 0101",
                         i, pg_if.tx_data_o, pg_if.tx_k_o);
            end
        end
        pg_if.inject_err_i = 1'b0;
        pg_if.start_gen_i  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge tx_clk); #1;
            check_idle_outputs("stop_from_align");
        end
        pg_if.start_gen_i = 1'b1;
        test_preamble(1);
    endtask

    task automatic test_async_reset();
        logic [31:0] exp_w;
        for (int i = 0; i < 4; i++) begin
            @(posedge tx_clk); #1;
            model_step(exp_w);
            checks++;
            if (pg_if.tx_data_o !== exp_w || pg_if.word_count_o !== 32'(i + 2)) begin
                errors++;
                $display("FAIL pre_reset_word_%0d: data=%h count=%0d, need %h %0d",
                         i, pg_if.tx_data_o, pg_if.word_count_o, exp_w, i + 2);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset_immediate");
        @(posedge tx_clk);
        @(posedge tx_clk); #1;
        check_idle_outputs("async_reset_held");
        #3 rst_n = 1'b1;
        test_preamble(1);
    endtask

    initial begin
        m_s = 7'h7F;
        pg_if.start_gen_i  = 1'b0;
        pg_if.inject_err_i = 1'b0;
        test_reset();
        test_preamble(2);
        test_prbs_period();
        test_inject();
        test_stop_restart();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prbs_pattern_gen.md
Name: prbs_pattern_gen

Overview:
- Loopback TX pattern generator.
- Sits directly downstream of the loopback startup delay stage and consumes its delayed start_gen level on start_gen_i.
- On start it sends an alignment preamble of K28.5/D16.2 words, then a continuous parallel PRBS7 stream for the transceiver TX lane.
- Supports single-word error injection so the checker path can be proven live.

Parameters:
DATA_WIDTH, 32, TX word width in bits; multiple of 8, range 8..64
ALIGN_WORDS, 16, number of alignment words sent before PRBS; range 1..255
PRBS_SEED, 7'h7F, LFSR load value; must be non-zero

Ports:
tx_clk_i  input  1  TX parallel clock; all logic on rising edge
pattern_gen_n_i  input  1  reset, asynchronous assert, active-low
start_gen_i  input  1  level from the startup stage; high = run
inject_err_i  input  1  single-cycle pulse requesting one corrupted word
tx_data_o  output  DATA_WIDTH  TX data word
tx_k_o  output  DATA_WIDTH/8  per-byte K-character flag; bit i qualifies tx_data_o[8i+7:8i]
pattern_valid_o  output  1  high while tx_data_o carries PRBS data
align_done_o  output  1  high once the preamble has completed, while in RUN
word_count_o  output  32  PRBS words sent since entering RUN, saturating

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Every register resets asynchronously when pattern_gen_n_i is low.
  - Reset values: state = IDLE, LFSR = PRBS_SEED, align counter = 0.
  - Reset values of outputs: tx_data_o = 0, tx_k_o = 0, pattern_valid_o = 0, align_done_o = 0, word_count_o = 0.
- Outputs are registered and update on the same edge as the state transition.
- IDLE:
  - Outputs are driven to their reset values; LFSR held at PRBS_SEED.
  - start_gen_i sampled high -> ALIGN. On that same edge tx_data_o loads the first alignment word.
- ALIGN:
  - Every word has even bytes = 8'hBC (K28.5, k=1) and odd bytes = 8'h50 (D16.2, k=0).
  - For DATA_WIDTH=32: tx_data_o = 32'h50BC50BC, tx_k_o = 4'b0101.
  - Exactly ALIGN_WORDS alignment words are sent, then -> RUN. The first PRBS word follows the last alignment word with no gap.
- RUN:
  - Each cycle emits DATA_WIDTH bits of PRBS7 (x^7+x^6+1). tx_k_o = 0; pattern_valid_o = 1; align_done_o = 1.
  - word_count_o increments once per PRBS word and saturates at 32'hFFFFFFFF.
- PRBS serial definition:
  - Per step: new = s[6] ^ s[5]; s <= {s[5:0], new}; output bit = new.
  - The first generated bit of a word goes to tx_data_o[DATA_WIDTH-1]; bits then fill MSB to LSB.
  - The LFSR advances DATA_WIDTH steps per cycle and is continuous across words. Sequence period = 127 bits.
- Error injection:
  - inject_err_i sampled high in RUN inverts bit 0 of the next emitted word only.
  - The LFSR is not affected, so the following words are correct.
  - Ignored in IDLE and ALIGN.
  - Pulses on consecutive cycles corrupt consecutive words.
- Stop and restart:
  - start_gen_i sampled low in ALIGN or RUN -> IDLE on that edge.
  - On that edge outputs return to their reset values, the LFSR reloads PRBS_SEED, the align counter clears and word_count_o clears.
  - A later start_gen_i high restarts with the full preamble.
- Reset mid-operation: immediate return to reset values, independent of clock. The preamble always restarts from word 0.
- start_gen_i is held stable by its source; this block adds no synchronizer.

Decomposition:
- Package xcvr_loopback_pkg holds:
  - K28_5 = 8'hBC and D16_2 = 8'h50
  - PRBS7 length/tap constants
  - state encoding IDLE/ALIGN/RUN
- Sub-module prbs7_par: purely combinational.
  - Inputs: 7-bit state, DATA_WIDTH parameter.
  - Outputs: DATA_WIDTH-bit word and next state.
  - Built by unrolling the serial step DATA_WIDTH times.
  - Reusable by the pattern checker.

Test Plan:
- Reset with start_gen_i=1 held -> all outputs 0 during reset. After release, the first word is 32'h50BC50BC with tx_k_o=4'b0101 on the first edge.
- start_gen_i rises in IDLE -> exactly 16 alignment words, then the first PRBS word with tx_data_o[31:24]=8'h02, pattern_valid_o=1, align_done_o=1, word_count_o=1 on the following cycle.
- Run 127 words -> the bitstream repeats with period 127 against a serial reference model; tx_k_o=0 throughout.
- inject_err_i pulse at RUN word 10 -> word 11 differs from the model only in bit 0; words 12+ match; LFSR uninterrupted.
- start_gen_i dropped at alignment word 5, re-raised 3 cycles later -> outputs 0 while low. The full 16-word preamble then repeats, and the PRBS restarts from seed (first byte 8'h02).
- pattern_gen_n_i pulsed low mid-RUN asynchronously (between edges) -> outputs clear immediately and word_count_o=0. Restart behaves as from power-up.
